led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Downstream stage of the 8-bit LED PIO output port: consumes the PIO's registered LED pattern and drives the board LED pins.
- Adds global PWM brightness and per-bit blinking, so software sets the pattern/duty/mask once instead of bit-banging.
- Pattern, duty and blink mask are shadowed and updated only at PWM period boundaries, giving glitch-free LED transitions.
- Sits between the PIO out_port wiring and the top-level LED pins.

Parameters:
- WIDTH, 8, number of LED bits (matches PIO out_port width).
- PRESCALE, 50, clk cycles per PWM tick; legal range >= 1.
- PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS ticks.
- BLINK_DIV, 16, PWM periods per blink phase toggle; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high; one clock, reset is synchronous and active-high.
- pattern_in  input  WIDTH  LED on/off pattern, driven from the PIO out_port.
- duty_in  input  PWM_BITS  global brightness; 0 = off, all-ones = fully on.
- blink_mask_in  input  WIDTH  1 = bit blinks, 0 = steady.
- led_out  output  WIDTH  registered LED drive, active-high.
- period_start  output  1  one-cycle pulse on every shadow load.

Behaviour:
- Reset (reset=1 at posedge) clears to 0: prescaler, pwm_cnt, blink_cnt, blink_phase, all shadows, led_out, period_start. Sets load_pending=1. Takes effect mid-operation on the same edge; no partial period survives.
- Prescaler counts 0..PRESCALE-1, then wraps to 0.
  - tick = (prescaler == PRESCALE-1).
  - PRESCALE=1 means tick every clock.
- pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0.
- boundary = tick && pwm_cnt == 2^PWM_BITS-1.
- Shadow load condition: load = boundary || load_pending.
  - On load: pat_s <= pattern_in, duty_s <= duty_in, mask_s <= blink_mask_in; period_start <= 1 (else 0).
  - load_pending clears on the first non-reset clock, so the first load happens one clock after reset deasserts.
- Input changes between loads have no effect on led_out.
- Blink, advanced only on boundary:
  - If blink_cnt == BLINK_DIV-1: blink_cnt <= 0 and blink_phase toggles.
  - Else: blink_cnt increments.
  - The load_pending load does not advance blink.
- on_pwm = 1 when duty_s == all-ones; else on_pwm = (pwm_cnt < duty_s), unsigned compare.
- Each clock: led_out[i] <= pat_s[i] & on_pwm & ~(mask_s[i] & blink_phase).
  - led_out is registered: it reflects counter and shadow state one clock later.
  - Pattern and duty reach the pin within 2 clocks of a load.
- Simultaneous input change on the load cycle: the value present at that edge is captured.

Test Plan (bench params: PRESCALE=2, PWM_BITS=4, BLINK_DIV=2; period = 32 clk):
- Reset release with pattern_in=8'hA5, duty_in=4'hF, mask=0 -> period_start pulses 1 clk after release; led_out=8'hA5 two clks after release and held steady for whole periods.
- duty_in=4, pattern 8'hFF -> per 32-clk period, led_out=8'hFF for exactly 8 clks, 8'h00 for 24; duty_in=0 -> led_out stays 8'h00.
- Change pattern_in 8'h0F->8'hF0 mid-period -> led_out keeps 8'h0F-based output until the next period_start, then switches cleanly.
- mask=8'h01, pattern 8'h03, duty 4'hF -> bit0 on for 2 periods (64 clk), off for 2, repeating; bit1 always on.
- Assert reset for 1 clk mid-period with led_out nonzero -> led_out=0 next clk; counters restart; reload 1 clk after release.
- Pattern/duty change exactly on the boundary clock -> new value captured at that edge; period_start aligned with the capture.

Source files
------------

// File: rtl/led_pwm_driver.sv
// LED PWM driver: global brightness plus per-bit blink; pattern/duty/mask shadowed at PWM period boundaries.
// led_out is registered one clock behind counter/shadow state; no handshake, inputs are sampled only on load.
module led_pwm_driver #(
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 50,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic [WIDTH-1:0]    blink_mask_in,
  output logic [WIDTH-1:0]    led_out,
  output logic                period_start
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0]     BL_LAST  = BL_W'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_s;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic                load_pending;
  logic [WIDTH-1:0]    pat_s;
  logic [WIDTH-1:0]    mask_s;
  logic                tick;
  logic                boundary;
  logic                load;
  logic                on_pwm;

  assign tick     = (prescaler == PS_LAST);
  assign boundary = tick && (pwm_cnt == PWM_LAST);
  assign load     = boundary || load_pending;
  // Full-scale duty must stay on through the last count, which a plain compare would drop.
  assign on_pwm   = (duty_s == PWM_LAST) || (pwm_cnt < duty_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler    <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      pat_s        <= '0;
      duty_s       <= '0;
      mask_s       <= '0;
      led_out      <= '0;
      period_start <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      prescaler    <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      // Blink advances on real period boundaries only, never on the post-reset load.
      if (boundary) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BL_W'(1);
        end
      end
      period_start <= load;
      if (load) begin
        pat_s  <= pattern_in;
        duty_s <= duty_in;
        mask_s <= blink_mask_in;
      end
      led_out <= pat_s & {WIDTH{on_pwm}} & ~(mask_s & {WIDTH{blink_phase}});
    end
  end
endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: closed-form timing model (edges since reset) against directed and random stimulus.
module tb_led_pwm_driver;
  localparam int W      = 8;
  localparam int P      = 2;
  localparam int B      = 4;
  localparam int BD     = 2;
  localparam int PERIOD = P * (1 << B);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pattern_in = '0;
  logic [B-1:0] duty_in = '0;
  logic [W-1:0] blink_mask_in = '0;
  logic [W-1:0] led_out;
  logic         period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_driver #(.WIDTH(W), .PRESCALE(P), .PWM_BITS(B), .BLINK_DIV(BD)) dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_in   (pattern_in),
    .duty_in      (duty_in),
    .blink_mask_in(blink_mask_in),
    .led_out      (led_out),
    .period_start (period_start)
  );

  // Reference: k = non-reset edges since reset. Before edge k+1 the pwm count is (k/P) mod 2^B,
  // boundaries so far are k/PERIOD, loads happen on edge 1 and every edge that is a multiple of PERIOD.
  int           k;
  int           m_pwm;
  int           m_phase;
  bit           m_on;
  logic [W-1:0] m_pat;
  logic [W-1:0] m_mask;
  logic [B-1:0] m_duty;
  logic [W-1:0] exp_led;
  logic         exp_ps;

  always @(posedge clk) begin
    if (reset) begin
      k       = 0;
      m_pat   = '0;
      m_mask  = '0;
      m_duty  = '0;
      exp_led = '0;
      exp_ps  = 1'b0;
    end else begin
      m_pwm   = (k / P) % (1 << B);
      m_phase = ((k / PERIOD) / BD) % 2;
      m_on    = (m_duty == {B{1'b1}}) || (m_pwm < int'(m_duty));
      exp_led = m_on ? (m_pat & ~((m_phase == 1) ? m_mask : '0)) : '0;
      k       = k + 1;
      exp_ps  = (k == 1) || (k % PERIOD == 0);
      if (exp_ps) begin
        m_pat  = pattern_in;
        m_duty = duty_in;
        m_mask = blink_mask_in;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    pattern_in = 8'hA5; duty_in = 4'hF; blink_mask_in = '0; reset = 1'b1;
    step(); step();
    checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b want 0", period_start); end
    reset = 1'b0;
    step();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL release_ps: got %b want 1", period_start); end
    checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL release_led1: got %h want 00", led_out); end
    step();
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL release_ps2: got %b want 0", period_start); end
    checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL release_led2: got %h want a5", led_out); end
    ok = 1'b1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (led_out !== 8'hA5) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL steady_a5: got %h want a5", led_out); end
  endtask

  task automatic test_duty();
    bit ok;
    int cnt;
    pattern_in = 8'hFF; duty_in = 4'd4;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL duty4_ps_timeout: got none want pulse"); end
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (led_out === 8'hFF) cnt++;
      checks++; if (led_out !== exp_led) begin errors++; $display("FAIL duty4_led: got %h want %h", led_out, exp_led); end
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL duty4_on_clks: got %0d want 8", cnt); end
    duty_in = 4'd0;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL duty0_ps_timeout: got none want pulse"); end
    ok = 1'b1;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (led_out !== 8'h00) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL duty0_led: got %h want 00", led_out); end
  endtask

  task automatic test_hold();
    bit ok;
    bit seen;
    pattern_in = 8'h0F; duty_in = 4'hF; blink_mask_in = '0;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_ps_timeout: got none want pulse"); end
    seen = 1'b0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      // Noise on the inputs until the boundary edge, which must sample F0.
      if ((k + 1) % PERIOD == 0) pattern_in = 8'hF0;
      else begin pattern_in = 8'($urandom); duty_in = 4'($urandom); end
      if ((k + 1) % PERIOD == 0) duty_in = 4'hF;
      step();
      checks++; if (led_out !== 8'h0F) begin errors++; $display("FAIL hold_old: got %h want 0f", led_out); end
      if (period_start === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_ps_timeout2: got none want pulse"); end
    step();
    checks++; if (led_out !== 8'hF0) begin errors++; $display("FAIL hold_new: got %h want f0", led_out); end
  endtask

  task automatic test_blink();
    bit ok;
    int cnt0;
    pattern_in = 8'h03; duty_in = 4'hF; blink_mask_in = 8'h01;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL blink_ps_timeout: got none want pulse"); end
    cnt0 = 0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      step();
      if (led_out[0] === 1'b1) cnt0++;
      checks++; if (led_out[1] !== 1'b1) begin errors++; $display("FAIL blink_bit1: got %b want 1", led_out[1]); end
      checks++; if (led_out !== exp_led) begin errors++; $display("FAIL blink_led: got %h want %h", led_out, exp_led); end
    end
    checks++; if (cnt0 != 2 * PERIOD) begin errors++; $display("FAIL blink_bit0_on: got %0d want %0d", cnt0, 2 * PERIOD); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int gap;
    pattern_in = 8'hFF; duty_in = 4'hF; blink_mask_in = '0;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mrst_ps_timeout: got none want pulse"); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (led_out !== 8'hFF) begin errors++; $display("FAIL mrst_pre: got %h want ff", led_out); end
    reset = 1'b1;
    step();
    checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL mrst_led: got %h want 00", led_out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL mrst_ps: got %b want 0", period_start); end
    reset = 1'b0;
    step();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL mrst_reload: got %b want 1", period_start); end
    step();
    checks++; if (led_out !== 8'hFF) begin errors++; $display("FAIL mrst_led2: got %h want ff", led_out); end
    gap = 1;
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      gap++;
      if (period_start === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || gap != PERIOD - 1) begin errors++; $display("FAIL mrst_period: got %0d want %0d", gap, PERIOD - 1); end
  endtask

  task automatic test_boundary_change();
    bit ok;
    pattern_in = 8'h81; duty_in = 4'hF; blink_mask_in = '0;
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (k % PERIOD == PERIOD - 1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bnd_align_timeout: got none want boundary"); end
    pattern_in = 8'h3C; duty_in = 4'hF;
    step();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL bnd_ps: got %b want 1", period_start); end
    checks++; if (led_out !== exp_led) begin errors++; $display("FAIL bnd_led0: got %h want %h", led_out, exp_led); end
    pattern_in = 8'h00; duty_in = 4'h0;
    step();
    checks++; if (led_out !== 8'h3C) begin errors++; $display("FAIL bnd_capture: got %h want 3c", led_out); end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (led_out !== 8'h3C) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bnd_hold: got %h want 3c", led_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) pattern_in = 8'($urandom);
      if ($urandom_range(7) == 0) duty_in = 4'($urandom);
      if ($urandom_range(7) == 0) blink_mask_in = 8'($urandom);
      reset = ($urandom_range(149) == 0);
      step();
      checks++; if (led_out !== exp_led) begin errors++; $display("FAIL rand_led: got %h want %h", led_out, exp_led); end
      checks++; if (period_start !== exp_ps) begin errors++; $display("FAIL rand_ps: got %b want %b", period_start, exp_ps); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty();
    test_hold();
    test_blink();
    test_mid_reset();
    test_boundary_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
